// File: rtl/execute_sequencer_pkg.sv
// Shared encodings for the execute-stage issue/retire controller.
// Result-select codes match the ALU result mux; FSM states are shared with the bench.
package execute_sequencer_pkg;

    localparam int unsigned REGADDR_WIDTH     = 5;
    localparam int unsigned RESLT_SELCT_WIDTH = 3;

    localparam logic [2:0] RS_ADD = 3'd0;
    localparam logic [2:0] RS_MUL = 3'd1;
    localparam logic [2:0] RS_DIV = 3'd2;
    localparam logic [2:0] RS_REM = 3'd3;
    localparam logic [2:0] RS_SLT = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MUL_WAIT  = 2'd1,
        ST_DIV_START = 2'd2,
        ST_DIV_WAIT  = 2'd3
    } state_t;

endpackage

// File: rtl/execute_sequencer_cycle_down_counter.sv
// Loadable down-counter shared by the multiply-latency and divide-timeout paths.
// o_zero flags the final tick: the cycle whose decrement lands the count on zero.
module cycle_down_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count <= WIDTH'(1));

endmodule

// File: rtl/execute_sequencer.sv
// Execute-stage issue/retire controller: accepts one decoded op per cycle, stalls
// the front end for multiply/divide, and drives the registered writeback strobe.
module execute_sequencer #(
    parameter int unsigned RESLT_SELCT_WIDTH = execute_sequencer_pkg::RESLT_SELCT_WIDTH,
    parameter int unsigned REGADDR_WIDTH     = execute_sequencer_pkg::REGADDR_WIDTH,
    parameter int unsigned MUL_LATENCY       = 3,
    parameter int unsigned DIV_TIMEOUT       = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         instr_valid,
    input  logic [RESLT_SELCT_WIDTH-1:0] result_select,
    input  logic [REGADDR_WIDTH-1:0]     write_select,
    input  logic                         write_enable,
    input  logic                         unsigned_select,
    input  logic                         div_done,
    output logic                         stall,
    output logic                         div_start,
    output logic                         div_unsigned,
    output logic                         wb_valid,
    output logic                         wb_write_enable,
    output logic [REGADDR_WIDTH-1:0]     wb_addr,
    output logic [RESLT_SELCT_WIDTH-1:0] wb_result_select,
    output logic                         error,
    output logic [31:0]                  retired_count
);

    import execute_sequencer_pkg::*;

    state_t                       r_state;
    state_t                       w_next_state;
    logic [RESLT_SELCT_WIDTH-1:0] r_sel;
    logic [REGADDR_WIDTH-1:0]     r_addr;
    logic                         r_we;
    logic                         r_uns;
    logic                         r_wb_valid;
    logic                         r_wb_we;
    logic [REGADDR_WIDTH-1:0]     r_wb_addr;
    logic [RESLT_SELCT_WIDTH-1:0] r_wb_sel;
    logic                         r_error;
    logic [31:0]                  r_retired;

    logic                         w_accept;
    logic                         w_retire_new;
    logic                         w_retire_held;
    logic                         w_err;
    logic                         w_cnt_load;
    logic [7:0]                   w_cnt_val;
    logic                         w_cnt_dec;
    logic                         w_cnt_zero;

    cycle_down_counter #(.WIDTH(8)) u_cnt (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_retire_new  = 1'b0;
        w_retire_held = 1'b0;
        w_err         = 1'b0;
        w_cnt_load    = 1'b0;
        w_cnt_val     = '0;
        w_cnt_dec     = 1'b0;
        stall         = (r_state != ST_IDLE);
        div_start     = (r_state == ST_DIV_START);
        div_unsigned  = (r_state == ST_DIV_START) && r_uns;
        case (r_state)
            ST_IDLE: begin
                if (instr_valid) begin
                    w_accept = 1'b1;
                    case (result_select)
                        RESLT_SELCT_WIDTH'(RS_ADD),
                        RESLT_SELCT_WIDTH'(RS_SLT): w_retire_new = 1'b1;
                        RESLT_SELCT_WIDTH'(RS_MUL): begin
                            if (MUL_LATENCY <= 1) begin
                                w_retire_new = 1'b1;
                            end else begin
                                w_next_state = ST_MUL_WAIT;
                                w_cnt_load   = 1'b1;
                                w_cnt_val    = 8'(MUL_LATENCY - 1);
                            end
                        end
                        RESLT_SELCT_WIDTH'(RS_DIV),
                        RESLT_SELCT_WIDTH'(RS_REM): w_next_state = ST_DIV_START;
                        default:                    w_err = 1'b1;
                    endcase
                end
            end
            ST_MUL_WAIT: begin
                w_cnt_dec = 1'b1;
                if (w_cnt_zero) begin
                    w_retire_held = 1'b1;
                    w_next_state  = ST_IDLE;
                end
            end
            ST_DIV_START: begin
                w_cnt_load   = 1'b1;
                w_cnt_val    = 8'(DIV_TIMEOUT);
                w_next_state = ST_DIV_WAIT;
            end
            ST_DIV_WAIT: begin
                // A done arriving on the final timeout tick still retires the op.
                if (div_done) begin
                    w_retire_held = 1'b1;
                    w_next_state  = ST_IDLE;
                end else if (w_cnt_zero) begin
                    w_err        = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel  <= '0;
            r_addr <= '0;
            r_we   <= 1'b0;
            r_uns  <= 1'b0;
        end else if (w_accept) begin
            r_sel  <= result_select;
            r_addr <= write_select;
            r_we   <= write_enable;
            r_uns  <= unsigned_select;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_valid <= 1'b0;
            r_wb_we    <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_sel   <= '0;
            r_error    <= 1'b0;
            r_retired  <= '0;
        end else begin
            r_wb_valid <= w_retire_new || w_retire_held;
            r_error    <= w_err;
            if (w_retire_new) begin
                r_wb_addr <= write_select;
                r_wb_sel  <= result_select;
                r_wb_we   <= write_enable && (write_select != '0);
            end else if (w_retire_held) begin
                r_wb_addr <= r_addr;
                r_wb_sel  <= r_sel;
                r_wb_we   <= r_we && (r_addr != '0);
            end
            if (r_wb_valid) r_retired <= r_retired + 32'd1;
        end
    end

    assign wb_valid         = r_wb_valid;
    assign wb_write_enable  = r_wb_valid && r_wb_we;
    assign wb_addr          = r_wb_addr;
    assign wb_result_select = r_wb_sel;
    assign error            = r_error;
    assign retired_count    = r_retired;

endmodule

// File: tb/tb_execute_sequencer.sv
// Directed bench for execute_sequencer: back-to-back ops, multiply latency,
// divide handshake, timeout, illegal op and reset mid-divide.
module tb_execute_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic [2:0]  result_select;
    logic [4:0]  write_select;
    logic        write_enable;
    logic        unsigned_select;
    logic        div_done;
    logic        stall;
    logic        div_start;
    logic        div_unsigned;
    logic        wb_valid;
    logic        wb_write_enable;
    logic [4:0]  wb_addr;
    logic [2:0]  wb_result_select;
    logic        error;
    logic [31:0] retired_count;

    int errors = 0;
    int checks = 0;

    execute_sequencer #(
        .RESLT_SELCT_WIDTH (3),
        .REGADDR_WIDTH     (5),
        .MUL_LATENCY       (3),
        .DIV_TIMEOUT       (64)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .instr_valid      (instr_valid),
        .result_select    (result_select),
        .write_select     (write_select),
        .write_enable     (write_enable),
        .unsigned_select  (unsigned_select),
        .div_done         (div_done),
        .stall            (stall),
        .div_start        (div_start),
        .div_unsigned     (div_unsigned),
        .wb_valid         (wb_valid),
        .wb_write_enable  (wb_write_enable),
        .wb_addr          (wb_addr),
        .wb_result_select (wb_result_select),
        .error            (error),
        .retired_count    (retired_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] sel, input logic [4:0] rd, input logic we, input logic uns);
        instr_valid     = 1'b1;
        result_select   = sel;
        write_select    = rd;
        write_enable    = we;
        unsigned_select = uns;
    endtask

    task automatic idle_in();
        instr_valid     = 1'b0;
        result_select   = 3'd0;
        write_select    = 5'd0;
        write_enable    = 1'b0;
        unsigned_select = 1'b0;
    endtask

    initial begin
        int n_err;
        int n_wb;
        int err_cyc;

        reset    = 1'b1;
        div_done = 1'b0;
        idle_in();
        step();
        step();
        chk("rst_stall", stall, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_error", error, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_count", retired_count, 0);
        reset = 1'b0;
        step();

        // back-to-back add rd3, slt rd7, add rd0
        issue(3'd0, 5'd3, 1'b1, 1'b0);
        chk("b2b_stall0", stall, 0);
        step();
        chk("b2b_v1", wb_valid, 1);
        chk("b2b_addr1", wb_addr, 3);
        chk("b2b_we1", wb_write_enable, 1);
        issue(3'd5, 5'd7, 1'b1, 1'b0);
        chk("b2b_stall1", stall, 0);
        step();
        chk("b2b_v2", wb_valid, 1);
        chk("b2b_addr2", wb_addr, 7);
        chk("b2b_we2", wb_write_enable, 1);
        chk("b2b_sel2", wb_result_select, 5);
        issue(3'd0, 5'd0, 1'b1, 1'b0);
        chk("b2b_stall2", stall, 0);
        step();
        chk("b2b_v3", wb_valid, 1);
        chk("b2b_addr3", wb_addr, 0);
        chk("b2b_we3_r0", wb_write_enable, 0);
        idle_in();
        step();
        chk("b2b_v_end", wb_valid, 0);
        chk("b2b_count", retired_count, 3);

        // multiply rd5 with a pending add held behind the stall
        issue(3'd1, 5'd5, 1'b1, 1'b0);
        step();
        chk("mul_stall_a1", stall, 1);
        chk("mul_v_a1", wb_valid, 0);
        issue(3'd0, 5'd6, 1'b1, 1'b0);
        div_done = 1'b1;
        step();
        div_done = 1'b0;
        chk("mul_stall_a2", stall, 1);
        chk("mul_v_a2", wb_valid, 0);
        step();
        chk("mul_v_a3", wb_valid, 1);
        chk("mul_sel_a3", wb_result_select, 1);
        chk("mul_addr_a3", wb_addr, 5);
        chk("mul_stall_a3", stall, 0);
        step();
        chk("mul_next_v", wb_valid, 1);
        chk("mul_next_addr", wb_addr, 6);
        chk("mul_next_sel", wb_result_select, 0);
        idle_in();
        step();
        chk("mul_count", retired_count, 5);

        // divu rd9: accepted at cycle 0, div_done at cycle 7
        issue(3'd2, 5'd9, 1'b1, 1'b1);
        chk("div_start_c0", div_start, 0);
        step();
        chk("div_start_c1", div_start, 1);
        chk("div_uns_c1", div_unsigned, 1);
        chk("div_stall_c1", stall, 1);
        idle_in();
        div_done = 1'b1;
        step();
        div_done = 1'b0;
        chk("div_start_c2", div_start, 0);
        chk("div_stall_c2", stall, 1);
        chk("div_v_c2", wb_valid, 0);
        for (int c = 3; c <= 7; c++) step();
        chk("div_v_c7", wb_valid, 0);
        chk("div_stall_c7", stall, 1);
        div_done = 1'b1;
        step();
        div_done = 1'b0;
        chk("div_v_c8", wb_valid, 1);
        chk("div_addr_c8", wb_addr, 9);
        chk("div_sel_c8", wb_result_select, 2);
        chk("div_we_c8", wb_write_enable, 1);
        chk("div_stall_c8", stall, 0);
        step();
        chk("div_count", retired_count, 6);

        // rem that never completes: error expected at A+66
        issue(3'd3, 5'd4, 1'b1, 1'b0);
        step();
        chk("to_start", div_start, 1);
        chk("to_uns", div_unsigned, 0);
        idle_in();
        n_err   = 0;
        n_wb    = 0;
        err_cyc = 0;
        for (int k = 2; k <= 80; k++) begin
            step();
            if (error) begin
                n_err++;
                if (err_cyc == 0) err_cyc = k;
            end
            if (wb_valid) n_wb++;
        end
        chk("to_err_pulses", n_err, 1);
        chk("to_err_cycle", err_cyc, 66);
        chk("to_no_wb", n_wb, 0);
        chk("to_idle", stall, 0);

        // illegal op
        issue(3'd6, 5'd2, 1'b1, 1'b0);
        step();
        chk("ill_err", error, 1);
        chk("ill_v", wb_valid, 0);
        chk("ill_stall", stall, 0);
        idle_in();
        step();
        chk("ill_err_clr", error, 0);
        chk("ill_count", retired_count, 6);

        // reset in DIV_WAIT, then a stray div_done
        issue(3'd2, 5'd10, 1'b1, 1'b0);
        step();
        idle_in();
        step();
        step();
        chk("rmd_stall_pre", stall, 1);
        reset = 1'b1;
        #1;
        chk("rmd_stall", stall, 0);
        chk("rmd_v", wb_valid, 0);
        chk("rmd_count", retired_count, 0);
        chk("rmd_addr", wb_addr, 0);
        step();
        reset    = 1'b0;
        div_done = 1'b1;
        step();
        div_done = 1'b0;
        step();
        chk("rmd_v_after", wb_valid, 0);
        chk("rmd_stall_after", stall, 0);
        chk("rmd_count_after", retired_count, 0);
        issue(3'd0, 5'd12, 1'b1, 1'b0);
        step();
        idle_in();
        chk("rmd_add_v", wb_valid, 1);
        chk("rmd_add_addr", wb_addr, 12);
        step();
        chk("rmd_add_count", retired_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
